approx_mul_err_accum: RTL and testbench
=======================================

// Module: approx_mul_err_accum
// PURPOSE
// - Error-metric collector directly downstream of an 8x8 approximate multiplier (Dadda tree + approximate FAs).
// - Takes each operand pair plus the multiplier's 16-bit product and recomputes the exact product.
// - Accumulates sum of squared error, sum of absolute error, max absolute error, erroneous-sample count and sample count.
// - Provides in-silicon MSE/MAE characterisation of one approx_fa configuration over a run of cfg_num samples.
// PARAMETERS
// - OP_W      8   operand width; product width is 2*OP_W
// - ACC_W     48  width of sum_sq and sum_abs accumulators (saturating)
// - CNT_W     32  width of sample/error counters and cfg_num
// PORTS
// - clk            in   1       single clock, rising edge
// - rst_n          in   1       reset, synchronous, active-low
// - start          in   1       1-cycle pulse: clear results, begin run
// - cfg_num        in   CNT_W   samples per run; sampled on start
// - in_valid       in   1       sample present
// - in_ready       out  1       collector accepts sample this cycle
// - in_a, in_b     in   OP_W    operands applied to the multiplier
// - in_approx      in   2*OP_W  approximate product from the multiplier
// - busy           out  1       state is RUN or DRAIN
// - done           out  1       level; run complete, results stable
// - res_sum_sq     out  ACC_W   sum of (approx-exact)^2
// - res_sum_abs    out  ACC_W   sum of |approx-exact|
// - res_max_abs    out  2*OP_W  max |approx-exact|
// - res_err_cnt    out  CNT_W   samples with approx != exact
// - res_smp_cnt    out  CNT_W   samples accumulated
// - res_sat        out  1       sticky: an accumulator saturated
// BEHAVIOUR
// - Clock/reset: one clock; reset is synchronous and active-low. While rst_n=0 at a clock edge:
//   - state=IDLE; all res_* = 0; busy=0; done=0; in_ready=0; pipeline valids=0.
// - FSM states IDLE, RUN, DRAIN, DONE.
//   - IDLE/DONE + start: clear all res_*, latch cfg_num, go RUN (or DONE next cycle if cfg_num=0).
//   - RUN: leave for DRAIN when accepted count reaches cfg_num.
//   - DRAIN: wait for both pipe stages empty, then DONE.
//   - start in RUN/DRAIN is ignored.
// - Handshake: in_ready = (state==RUN) && (accepted < cfg_num). A sample transfers when in_valid && in_ready.
//   - Inputs held by the source until the transfer; no input buffering.
// - Pipeline, 2 stages, never stalls:
//   - S1 registers err = $signed({1'b0,approx}) - $signed({1'b0,a*b}) (2*OP_W+1 bits signed), its abs, and err!=0.
//   - S2 registers err*err (4*OP_W+2 bits) and updates accumulators.
//   - Sample transferred at edge t is reflected in res_* after edge t+2.
// - Arithmetic: sum_sq, sum_abs saturate at all-ones and set res_sat; counters wrap is impossible (bounded by cfg_num).
//   - res_max_abs updates when abs > current.
// - done rises the cycle after DRAIN finds pipe empty; held until next start or reset.
// - res_* are readable at any time; mid-run values are partial.
// STRUCTURE
// - Package approx_err_pkg: OP_W/ACC_W/CNT_W defaults, state enum typedef, saturating-add function.
// - Sub-module err_metric_pipe: the 2-stage exact-product/err/square datapath with valid bit.
//   - FSM, handshake and accumulators stay in the top.
// TESTING
// - Exact path: cfg_num=4, approx=a*b for (3,5),(255,255),(0,7),(16,16)
//   -> all sums 0, err_cnt 0, smp_cnt 4, done=1.
// - Single error: cfg_num=1, a=3,b=5,approx=13
//   -> sum_sq 4, sum_abs 2, max_abs 2, err_cnt 1, done exactly 3 cycles after transfer edge.
// - Back-pressure/gaps: cfg_num=3, in_valid toggling 1,0,1,0,1 with approx=exact+1
//   -> sum_sq 3, sum_abs 3; in_ready drops to 0 after 3rd transfer; extra valid not consumed.
// - cfg_num=0 start -> DONE next cycle, all res_*=0, in_ready never 1.
// - Saturation: ACC_W=8, cfg_num=2, a=b=0, approx=16 (sq 256 each) -> res_sum_sq=255, res_sat=1.
// - Reset mid-run: rst_n low 1 cycle during RUN
//   -> next cycle IDLE, all res_*=0, busy=0, done=0; start afterwards runs normally.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared defaults, FSM state type and saturating-add helpers for the
// approximate-multiplier error collector.
package approx_err_pkg;

  localparam int unsigned OP_W_DEF  = 8;
  localparam int unsigned ACC_W_DEF = 48;
  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned SAT_W     = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Operands are zero-extended to SAT_W; w is the real accumulator width.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

  function automatic logic sat_ovf(input logic [SAT_W-1:0] acc,
                                   input logic [SAT_W-1:0] inc,
                                   input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    return sum > lim;
  endfunction

endpackage

// File: rtl/err_metric_pipe.sv
// Two-stage datapath: exact product and signed error in S1, squared error in S2.
// Never stalls; busy reports any stage still holding a valid sample.
module err_metric_pipe
  import approx_err_pkg::*;
#(
  parameter int unsigned OP_W = OP_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  input  logic [2*OP_W-1:0]   in_approx,
  output logic                out_valid,
  output logic [2*OP_W-1:0]   out_abs,
  output logic                out_nz,
  output logic [4*OP_W+1:0]   out_sq,
  output logic                busy
);

  localparam int unsigned PW  = 2 * OP_W;
  localparam int unsigned EW  = PW + 1;
  localparam int unsigned SQW = 4 * OP_W + 2;

  logic [PW-1:0]         prod;
  logic signed [EW-1:0]  err;
  logic [PW-1:0]         abs_c;

  logic                  v1;
  logic signed [EW-1:0]  err1;
  logic [PW-1:0]         abs1;
  logic                  nz1;

  logic signed [SQW-1:0] err1_ext;

  always_comb begin
    prod  = PW'(in_a) * PW'(in_b);
    err   = $signed({1'b0, in_approx}) - $signed({1'b0, prod});
    abs_c = err[EW-1] ? PW'(-err) : PW'(err);
  end

  always_comb begin
    err1_ext = SQW'(err1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
    end
  end

  always_ff @(posedge clk) begin
    err1    <= err;
    abs1    <= abs_c;
    nz1     <= (err != '0);
    out_sq  <= $unsigned(err1_ext * err1_ext);
    out_abs <= abs1;
    out_nz  <= nz1;
  end

  always_comb begin
    busy = v1 | out_valid;
  end

endmodule

// File: rtl/approx_mul_err_accum.sv
// Error-metric collector for an 8x8 approximate multiplier: run FSM, input
// handshake and saturating MSE/MAE accumulators around err_metric_pipe.
module approx_mul_err_accum
  import approx_err_pkg::*;
#(
  parameter int unsigned OP_W  = OP_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_num,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  input  logic [2*OP_W-1:0]   in_approx,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    res_sum_sq,
  output logic [ACC_W-1:0]    res_sum_abs,
  output logic [2*OP_W-1:0]   res_max_abs,
  output logic [CNT_W-1:0]    res_err_cnt,
  output logic [CNT_W-1:0]    res_smp_cnt,
  output logic                res_sat
);

  localparam int unsigned PW  = 2 * OP_W;
  localparam int unsigned SQW = 4 * OP_W + 2;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cfg_q;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] accepted_inc;
  logic             start_ok;
  logic             fire;

  logic             p_valid;
  logic [PW-1:0]    p_abs;
  logic             p_nz;
  logic [SQW-1:0]   p_sq;
  logic             p_busy;

  err_metric_pipe #(
    .OP_W(OP_W)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fire),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_approx(in_approx),
    .out_valid(p_valid),
    .out_abs  (p_abs),
    .out_nz   (p_nz),
    .out_sq   (p_sq),
    .busy     (p_busy)
  );

  always_comb begin
    start_ok     = start && (state == S_IDLE || state == S_DONE);
    fire         = in_valid && in_ready;
    accepted_inc = accepted + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (cfg_num == '0) ? S_DONE : S_RUN;
      S_RUN:          if (fire && accepted_inc == cfg_q) state_nxt = S_DRAIN;
      S_DRAIN:        if (!p_busy) state_nxt = S_DONE;
    endcase
  end

  always_comb begin
    busy     = (state == S_RUN) || (state == S_DRAIN);
    done     = (state == S_DONE);
    in_ready = (state == S_RUN) && (accepted < cfg_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      accepted <= '0;
    end else if (start_ok) begin
      cfg_q    <= cfg_num;
      accepted <= '0;
    end else if (fire) begin
      accepted <= accepted_inc;
    end
  end

  // Pipe is always empty in IDLE/DONE, so a start clear never races an update.
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      res_sum_sq  <= '0;
      res_sum_abs <= '0;
      res_max_abs <= '0;
      res_err_cnt <= '0;
      res_smp_cnt <= '0;
      res_sat     <= 1'b0;
    end else if (p_valid) begin
      res_sum_sq  <= ACC_W'(sat_add(SAT_W'(res_sum_sq), SAT_W'(p_sq), ACC_W));
      res_sum_abs <= ACC_W'(sat_add(SAT_W'(res_sum_abs), SAT_W'(p_abs), ACC_W));
      res_sat     <= res_sat
                   | sat_ovf(SAT_W'(res_sum_sq), SAT_W'(p_sq), ACC_W)
                   | sat_ovf(SAT_W'(res_sum_abs), SAT_W'(p_abs), ACC_W);
      if (p_abs > res_max_abs) res_max_abs <= p_abs;
      if (p_nz) res_err_cnt <= res_err_cnt + CNT_W'(1);
      res_smp_cnt <= res_smp_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_approx_mul_err_accum.sv
// Directed bench for approx_mul_err_accum: table of complete runs plus
// hand sequences for latency, back-pressure, empty run, saturation and reset.
module tb_approx_mul_err_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] cfg_num;
  logic        in_valid;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_approx;

  logic        in_ready, busy, done, res_sat;
  logic [47:0] res_sum_sq, res_sum_abs;
  logic [15:0] res_max_abs;
  logic [31:0] res_err_cnt, res_smp_cnt;

  logic        s_in_ready, s_busy, s_done, s_res_sat;
  logic [7:0]  s_sum_sq, s_sum_abs;
  logic [15:0] s_max_abs;
  logic [31:0] s_err_cnt, s_smp_cnt;

  always #5 clk = ~clk;

  approx_mul_err_accum u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num(cfg_num),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy), .done(done),
    .res_sum_sq(res_sum_sq), .res_sum_abs(res_sum_abs), .res_max_abs(res_max_abs),
    .res_err_cnt(res_err_cnt), .res_smp_cnt(res_smp_cnt), .res_sat(res_sat)
  );

  approx_mul_err_accum #(.ACC_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num(cfg_num),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(s_busy), .done(s_done),
    .res_sum_sq(s_sum_sq), .res_sum_abs(s_sum_abs), .res_max_abs(s_max_abs),
    .res_err_cnt(s_err_cnt), .res_smp_cnt(s_smp_cnt), .res_sat(s_res_sat)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } smp_t;

  typedef struct {
    string           name;
    int unsigned     cfg;
    int unsigned     first;
    longint unsigned sq;
    longint unsigned ab;
    longint unsigned mx;
    longint unsigned ec;
  } vec_t;

  smp_t samples [10];
  vec_t vecs [4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned cfg);
    cfg_num = cfg;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input smp_t s);
    int cnt = 0;
    in_a = s.a; in_b = s.b; in_approx = s.p;
    in_valid = 1'b1;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("send_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cnt = 0;
    while (!done && cnt < 50) begin
      tick();
      cnt++;
    end
    chk({name, ".done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic run_vec(input int i);
    do_start(vecs[i].cfg);
    for (int k = 0; k < int'(vecs[i].cfg); k++) send(samples[vecs[i].first + k]);
    wait_done(vecs[i].name);
    chk({vecs[i].name, ".sum_sq"},  res_sum_sq,  vecs[i].sq);
    chk({vecs[i].name, ".sum_abs"}, res_sum_abs, vecs[i].ab);
    chk({vecs[i].name, ".max_abs"}, res_max_abs, vecs[i].mx);
    chk({vecs[i].name, ".err_cnt"}, res_err_cnt, vecs[i].ec);
    chk({vecs[i].name, ".smp_cnt"}, res_smp_cnt, 64'(vecs[i].cfg));
    chk({vecs[i].name, ".busy"},    {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bit pat [7];
    int xfers;
    bit ck;
    bit seen_ready;

    samples = '{
      '{8'd3,   8'd5,   16'd15},    '{8'd255, 8'd255, 16'd65025},
      '{8'd0,   8'd7,   16'd0},     '{8'd16,  8'd16,  16'd256},
      '{8'd3,   8'd5,   16'd13},
      '{8'd10,  8'd10,  16'd110},   '{8'd2,   8'd3,   16'd0},
      '{8'd200, 8'd100, 16'd20000},
      '{8'd255, 8'd255, 16'd0},     '{8'd0,   8'd0,   16'd65535}
    };
    vecs = '{
      '{"exact",   4, 0, 64'd0,          64'd0,      64'd0,     64'd0},
      '{"single",  1, 4, 64'd4,          64'd2,      64'd2,     64'd1},
      '{"mixed",   3, 5, 64'd136,        64'd16,     64'd10,    64'd2},
      '{"extreme", 2, 8, 64'd8523086850, 64'd130560, 64'd65535, 64'd2}
    };
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; cfg_num = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_approx = '0;
    tick(); tick();
    chk("rst.busy",     {63'd0, busy},     64'd0);
    chk("rst.done",     {63'd0, done},     64'd0);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst.sum_sq",   res_sum_sq,        64'd0);
    chk("rst.smp_cnt",  res_smp_cnt,       64'd0);
    chk("rst.sat",      {63'd0, res_sat},  64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(i);

    // Latency: transfer edge t, results after t+2, done after t+3.
    do_start(1);
    in_a = 8'd3; in_b = 8'd5; in_approx = 16'd13; in_valid = 1'b1;
    chk("lat.ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("lat.t0.sum_sq", res_sum_sq, 64'd0);
    chk("lat.t0.done",   {63'd0, done}, 64'd0);
    tick();
    chk("lat.t1.sum_sq", res_sum_sq, 64'd0);
    chk("lat.t1.done",   {63'd0, done}, 64'd0);
    tick();
    chk("lat.t2.sum_sq", res_sum_sq, 64'd4);
    chk("lat.t2.done",   {63'd0, done}, 64'd0);
    tick();
    chk("lat.t3.done",   {63'd0, done}, 64'd1);

    // Back-pressure with gaps: approx = exact + 1, only 3 samples consumed.
    do_start(3);
    in_a = 8'd3; in_b = 8'd5; in_approx = 16'd16;
    xfers = 0; ck = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      if (in_valid && in_ready) xfers++;
      tick();
      if (xfers == 3 && !ck) begin
        chk("bp.ready_drop", {63'd0, in_ready}, 64'd0);
        ck = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("bp.xfers", 64'(xfers), 64'd3);
    wait_done("bp");
    chk("bp.sum_sq",  res_sum_sq,  64'd3);
    chk("bp.sum_abs", res_sum_abs, 64'd3);
    chk("bp.max_abs", res_max_abs, 64'd1);
    chk("bp.err_cnt", res_err_cnt, 64'd3);
    chk("bp.smp_cnt", res_smp_cnt, 64'd3);

    // Empty run.
    seen_ready = in_ready;
    do_start(0);
    chk("zero.done", {63'd0, done}, 64'd1);
    chk("zero.busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      seen_ready |= in_ready;
      tick();
    end
    chk("zero.ready_seen", {63'd0, seen_ready}, 64'd0);
    chk("zero.sum_sq",  res_sum_sq,  64'd0);
    chk("zero.sum_abs", res_sum_abs, 64'd0);
    chk("zero.max_abs", res_max_abs, 64'd0);
    chk("zero.err_cnt", res_err_cnt, 64'd0);
    chk("zero.smp_cnt", res_smp_cnt, 64'd0);

    // Saturation in the 8-bit accumulator instance; 48-bit one does not saturate.
    do_start(2);
    send('{8'd0, 8'd0, 16'd16});
    send('{8'd0, 8'd0, 16'd16});
    wait_done("sat");
    chk("sat.narrow.sum_sq",  s_sum_sq,  64'd255);
    chk("sat.narrow.sat",     {63'd0, s_res_sat}, 64'd1);
    chk("sat.narrow.sum_abs", s_sum_abs, 64'd32);
    chk("sat.wide.sum_sq",    res_sum_sq, 64'd512);
    chk("sat.wide.sat",       {63'd0, res_sat}, 64'd0);

    // Reset in the middle of a run, then a normal run.
    do_start(5);
    send(samples[5]);
    send(samples[6]);
    tick();
    chk("mid.partial_smp", res_smp_cnt, 64'd1);
    chk("mid.busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mid.busy",     {63'd0, busy},     64'd0);
    chk("mid.done",     {63'd0, done},     64'd0);
    chk("mid.in_ready", {63'd0, in_ready}, 64'd0);
    chk("mid.sum_sq",   res_sum_sq,        64'd0);
    chk("mid.sum_abs",  res_sum_abs,       64'd0);
    chk("mid.max_abs",  res_max_abs,       64'd0);
    chk("mid.smp_cnt",  res_smp_cnt,       64'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mid.post_smp", res_smp_cnt, 64'd0);
    run_vec(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
